// File: rtl/pc_return_stack_if.sv
// Control-unit <-> return-stack signal bundle: push/pop requests in, top-of-stack and status out.
interface pc_return_stack_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] from_stack;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din, clr_err,
        input  from_stack, level, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output from_stack, level, empty, full, ovf, unf
    );
endinterface

// File: rtl/pc_return_stack.sv
// Hardware return-address stack feeding the PC's FROM_STACK input, with sticky
// overflow/underflow flags. The top entry is read combinationally from registered state.
module pc_return_stack #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pc_return_stack_if.slave     bus
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             is_empty, is_full;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [LW-1:0]    sp_m1;
    logic             ovf_set, unf_set;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == LW'(DEPTH));
    assign sp_m1    = sp_q - LW'(1);

    always_comb begin
        we      = 1'b0;
        waddr   = sp_q[AW-1:0];
        sp_d    = sp_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.push && bus.pop) begin
            // Replace the top; on an empty stack this degenerates to a plain push.
            we = 1'b1;
            if (is_empty) begin
                waddr = '0;
                sp_d  = LW'(1);
            end else begin
                waddr = sp_m1[AW-1:0];
            end
        end else if (bus.push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                we    = 1'b1;
                waddr = sp_q[AW-1:0];
                sp_d  = sp_q + LW'(1);
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                unf_set = 1'b1;
            end else begin
                sp_d = sp_m1;
            end
        end
        // A new error on the same edge as a clear leaves the flag set.
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        unf_d = unf_set | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (we) begin
                mem_q[waddr] <= bus.din;
            end
        end
    end

    assign bus.from_stack = is_empty ? '0 : mem_q[sp_m1[AW-1:0]];
    assign bus.level      = sp_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack (DEPTH=4) with a small PC model for the RET path.
module tb_pc_return_stack;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        string      name;
        logic [9:0] top;
        logic [2:0] level;
        bit         empty;
        bit         full;
        bit         ovf;
        bit         unf;
        bit         chk_pc;
        logic [9:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pc_ld = 1'b0;
    logic [9:0] pc_count = '0;
    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];
    event obs;

    pc_return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Simple PC: loads the stack top when its mux selects the stack source.
    always @(posedge clk) begin
        if (pc_ld) pc_count <= bus.from_stack;
    end

    function automatic exp_t mk(string name, logic [9:0] top, logic [2:0] lvl, bit ovf, bit unf);
        exp_t e;
        e.name = name; e.top = top; e.level = lvl;
        e.empty = (lvl == 3'd0); e.full = (lvl == 3'd4);
        e.ovf = ovf; e.unf = unf; e.chk_pc = 1'b0; e.pc = '0;
        return e;
    endfunction

    task automatic expect_now(input exp_t e);
        sb_q.push_back(e);
        ->obs;
        #1;
    endtask

    task automatic step(input bit ps, input bit po, input logic [9:0] d, input bit clr,
                        input bit ld, input exp_t e);
        bus.push = ps; bus.pop = po; bus.din = d; bus.clr_err = clr; pc_ld = ld;
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = 'x; bus.clr_err = 1'b0; pc_ld = 1'b0;
        expect_now(e);
    endtask

    // Monitor: compares DUT outputs against each queued expectation as it is presented.
    initial begin
        exp_t e;
        forever begin
            @(obs);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (bus.level !== e.level || bus.from_stack !== e.top || bus.empty !== e.empty ||
                    bus.full !== e.full || bus.ovf !== e.ovf || bus.unf !== e.unf ||
                    (e.chk_pc && pc_count !== e.pc)) begin
                    n_fail++;
                    $display("FAIL %s: got lvl=%0d top=%h empty=%b full=%b ovf=%b unf=%b pc=%h; want lvl=%0d top=%h empty=%b full=%b ovf=%b unf=%b pc=%h",
                             e.name, bus.level, bus.from_stack, bus.empty, bus.full, bus.ovf,
                             bus.unf, pc_count, e.level, e.top, e.empty, e.full, e.ovf, e.unf,
                             e.chk_pc ? e.pc : pc_count);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
        #2;
        expect_now(mk("reset_state", 10'h000, 3'd0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // Push/pop order
        step(1, 0, 10'h010, 0, 0, mk("push_010", 10'h010, 3'd1, 0, 0));
        step(1, 0, 10'h025, 0, 0, mk("push_025", 10'h025, 3'd2, 0, 0));
        step(1, 0, 10'h3FF, 0, 0, mk("push_3ff", 10'h3FF, 3'd3, 0, 0));
        step(0, 1, 10'h000, 0, 0, mk("pop_to_025", 10'h025, 3'd2, 0, 0));
        step(0, 1, 10'h000, 0, 0, mk("pop_to_010", 10'h010, 3'd1, 0, 0));
        step(0, 1, 10'h000, 0, 0, mk("pop_to_empty", 10'h000, 3'd0, 0, 0));

        // Overflow
        step(1, 0, 10'h001, 0, 0, mk("fill_1", 10'h001, 3'd1, 0, 0));
        step(1, 0, 10'h002, 0, 0, mk("fill_2", 10'h002, 3'd2, 0, 0));
        step(1, 0, 10'h003, 0, 0, mk("fill_3", 10'h003, 3'd3, 0, 0));
        step(1, 0, 10'h004, 0, 0, mk("fill_full", 10'h004, 3'd4, 0, 0));
        step(1, 0, 10'h155, 0, 0, mk("push_when_full", 10'h004, 3'd4, 1, 0));
        step(1, 1, 10'h0EE, 0, 0, mk("replace_when_full", 10'h0EE, 3'd4, 1, 0));
        step(0, 1, 10'h000, 0, 0, mk("pop_after_ovf", 10'h003, 3'd3, 1, 0));
        step(0, 0, 10'h000, 0, 0, mk("hold", 10'h003, 3'd3, 1, 0));
        step(0, 1, 10'h000, 0, 0, mk("drain_2", 10'h002, 3'd2, 1, 0));
        step(0, 1, 10'h000, 0, 0, mk("drain_1", 10'h001, 3'd1, 1, 0));
        step(0, 1, 10'h000, 1, 0, mk("drain_clr_ovf", 10'h000, 3'd0, 0, 0));

        // Underflow and clear
        step(0, 1, 10'h000, 0, 0, mk("pop_empty_unf", 10'h000, 3'd0, 0, 1));
        step(0, 1, 10'h000, 1, 0, mk("clr_with_unf", 10'h000, 3'd0, 0, 1));
        step(0, 0, 10'h000, 1, 0, mk("clr_alone", 10'h000, 3'd0, 0, 0));

        // Simultaneous push+pop
        step(1, 0, 10'h020, 0, 0, mk("push_020", 10'h020, 3'd1, 0, 0));
        step(1, 0, 10'h030, 0, 0, mk("push_030", 10'h030, 3'd2, 0, 0));
        step(1, 1, 10'h0AB, 0, 0, mk("replace_top", 10'h0AB, 3'd2, 0, 0));
        step(0, 1, 10'h000, 0, 0, mk("below_intact", 10'h020, 3'd1, 0, 0));
        step(0, 1, 10'h000, 0, 0, mk("pop_to_empty2", 10'h000, 3'd0, 0, 0));
        step(1, 1, 10'h011, 0, 0, mk("pushpop_empty", 10'h011, 3'd1, 0, 0));

        // Asynchronous reset mid-cycle with SP=3
        step(1, 0, 10'h022, 0, 0, mk("pre_rst_2", 10'h022, 3'd2, 0, 0));
        step(1, 0, 10'h155, 0, 0, mk("pre_rst_3", 10'h155, 3'd3, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        expect_now(mk("async_reset", 10'h000, 3'd0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // PC integration: CALL then single-cycle RET
        step(1, 0, 10'h100, 0, 0, mk("call_outer", 10'h100, 3'd1, 0, 0));
        step(1, 0, 10'h046, 0, 0, mk("call_046", 10'h046, 3'd2, 0, 0));
        e = mk("ret_pc_load", 10'h100, 3'd1, 0, 0);
        e.chk_pc = 1'b1;
        e.pc = 10'h046;
        step(0, 1, 10'h000, 0, 1, e);

        #2;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Hardware return-address stack for the RAT CPU.
- Sits directly upstream of the program counter block and drives its FROM_STACK input.
- Control unit asserts PUSH on CALL (DIN = return address) and POP on RET. The PC loads FROM_STACK when its mux selects the stack source.
- Provides fill level, full/empty status and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 10, bit width of each stored address; matches PC_COUNT width.
- DEPTH, 8, number of entries; legal range 2..32.
- LW, $clog2(DEPTH+1), width of LEVEL (derived, not overridden).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- PUSH  input  1  push DIN onto stack this cycle.
- POP  input  1  pop top entry this cycle.
- DIN  input  WIDTH  return address to push.
- CLR_ERR  input  1  synchronous clear of OVF/UNF.
- FROM_STACK  output  WIDTH  current top-of-stack entry (combinational from registered state).
- LEVEL  output  LW  number of valid entries, 0..DEPTH.
- EMPTY  output  1  LEVEL == 0.
- FULL  output  1  LEVEL == DEPTH.
- OVF  output  1  sticky: push attempted while full.
- UNF  output  1  sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH x WIDTH register array plus stack pointer SP (= LEVEL, 0..DEPTH). Entry k is valid for k < SP; top is entry SP-1.
- Reset (RST=1, asynchronous):
  - SP=0; all entries cleared to 0; OVF=0, UNF=0.
  - Outputs during and after reset: FROM_STACK=0, LEVEL=0, EMPTY=1, FULL=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- FROM_STACK:
  - Equals entry SP-1 when SP>0, and 0 when EMPTY.
  - Reflects a push or pop in the same cycle the edge occurs: zero latency after the edge, no extra pipeline stage.
  - Must be stable before the PC's next edge so that a RET's pop and PC load line up per control-unit timing (see next bullet).
- Single-cycle RET: the control unit asserts POP in the same cycle the PC loads FROM_STACK. The PC captures the pre-pop top value on that edge; the stack decrements on the same edge.
- Per rising edge, operations are evaluated in priority order:
  1. PUSH=1, POP=0, not full: entry[SP] <= DIN; SP <= SP+1.
  2. PUSH=1, POP=0, full: no state change; OVF <= 1.
  3. PUSH=0, POP=1, not empty: SP <= SP-1; the vacated entry is not required to be cleared.
  4. PUSH=0, POP=1, empty: no state change; UNF <= 1.
  5. PUSH=1, POP=1, not empty: replace the top (entry[SP-1] <= DIN); SP unchanged; no flag change. This holds when full as well.
  6. PUSH=1, POP=1, empty: treated as a plain push (entry[0] <= DIN, SP <= 1); UNF not set.
  7. PUSH=0, POP=0: hold.
- Flags:
  - OVF and UNF remain set until RST or CLR_ERR.
  - CLR_ERR=1 clears both on the edge.
  - If a new error occurs on the same edge as CLR_ERR, the set wins (flag ends at 1).
- Wrap-around: none. SP never exceeds DEPTH and never goes below 0. Overflowing pushes are dropped, not wrapped.
- DIN is captured only on edges where a write occurs. X on DIN is tolerated otherwise.
- LEVEL, EMPTY and FULL are pure functions of SP.

Test Plan:
- Reset check: RST pulse mid-cycle with SP=3 -> immediately LEVEL=0, EMPTY=1, FROM_STACK=0, OVF=UNF=0, with no clock edge required.
- Push/pop order: DEPTH=4; push 0x010, 0x025, 0x3FF -> LEVEL=3, FROM_STACK=0x3FF. Three pops -> FROM_STACK goes 0x025, 0x010, 0; EMPTY=1.
- Overflow: DEPTH=4; fill with 0x001..0x004 (FULL=1), then push 0x155 -> FROM_STACK stays 0x004, LEVEL=4, OVF=1. Pop -> FROM_STACK=0x003, OVF stays 1.
- Underflow and clear: empty stack, POP -> UNF=1, LEVEL=0. CLR_ERR together with another POP -> UNF stays 1. CLR_ERR alone -> UNF=0.
- Simultaneous ops: stack holds 0x020, 0x030; PUSH+POP with DIN=0x0AB -> LEVEL=2, FROM_STACK=0x0AB, next entry down still 0x020. On an empty stack, PUSH+POP with DIN=0x011 -> LEVEL=1, FROM_STACK=0x011, UNF=0.
- PC integration: CALL pushes 0x046. On the RET cycle POP is asserted and the PC selects the stack source -> PC_COUNT=0x046 after the edge, LEVEL decremented on the same edge.
